// File: rtl/wbs_sram_ctrl_if.sv
// Wishbone classic bus between the UART bridge (master) and the SRAM controller (slave).
// Signal names keep the slave-side spelling so both ends trace back to one port list.
interface wbs_sram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                    wb_cyc_i;
    logic                    wb_stb_i;
    logic                    wb_we_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_i;
    logic [ADDR_WIDTH-1:0]   wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wbs_sram_ctrl.sv
// Wishbone classic slave in front of a single-port synchronous SRAM macro.
// One ack per strobe; read data is held on wb_dat_o until the next read capture.
module wbs_sram_ctrl #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    MEM_ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h3000_0000,
    parameter int                    READ_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    wbs_sram_ctrl_if.slave            wb,
    output logic                      sram_csb_o,
    output logic                      sram_web_o,
    output logic [DATA_WIDTH/8-1:0]   sram_wmask_o,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0]     sram_din_o,
    input  logic [DATA_WIDTH-1:0]     sram_dout_i,
    output logic                      o_range_err,
    output logic                      o_busy
);
    localparam int         SEL_W  = DATA_WIDTH / 8;
    localparam logic [1:0] RL_CNT = 2'(READ_LATENCY);

    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, ACK, HOLD} state_t;

    state_t                    state, state_nxt;
    logic [1:0]                cnt, cnt_nxt;
    logic                      ack_q, ack_nxt;
    logic [DATA_WIDTH-1:0]     dat_q, dat_nxt;
    logic                      csb_nxt, web_nxt, rerr_nxt;
    logic [SEL_W-1:0]          wmask_nxt;
    logic [MEM_ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0]     din_nxt;

    logic                      req, in_win;
    logic [MEM_ADDR_WIDTH-1:0] word_addr;
    logic                      unused_adr;

    assign req        = wb.wb_cyc_i & wb.wb_stb_i;
    assign in_win     = wb.wb_adr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2]
                        == BASE_ADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
    assign word_addr  = wb.wb_adr_i[MEM_ADDR_WIDTH+1:2];
    // Byte offset within a word plays no part in the access.
    assign unused_adr = ^wb.wb_adr_i[1:0];

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        rerr_nxt  = 1'b0;
        csb_nxt   = 1'b1;
        web_nxt   = 1'b1;
        wmask_nxt = '0;
        addr_nxt  = sram_addr_o;
        din_nxt   = sram_din_o;
        dat_nxt   = dat_q;

        unique case (state)
            IDLE: begin
                if (req) begin
                    if (!in_win) begin
                        ack_nxt   = 1'b1;
                        rerr_nxt  = 1'b1;
                        if (!wb.wb_we_i) dat_nxt = '0;
                        state_nxt = HOLD;
                    end else begin
                        csb_nxt  = 1'b0;
                        addr_nxt = word_addr;
                        if (wb.wb_we_i) begin
                            web_nxt   = 1'b0;
                            din_nxt   = wb.wb_dat_i;
                            wmask_nxt = wb.wb_sel_i;
                            state_nxt = WR;
                        end else begin
                            cnt_nxt   = RL_CNT;
                            state_nxt = RD_WAIT;
                        end
                    end
                end
            end
            WR: begin
                // The write was already issued; dropping cyc only suppresses the ack.
                if (!wb.wb_cyc_i) begin
                    state_nxt = IDLE;
                end else begin
                    ack_nxt   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            RD_WAIT: begin
                if (!wb.wb_cyc_i) begin
                    state_nxt = IDLE;
                end else if (cnt == 2'd1) begin
                    dat_nxt   = sram_dout_i;
                    ack_nxt   = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            HOLD: begin
                if (!wb.wb_cyc_i || !wb.wb_stb_i) state_nxt = IDLE;
            end
            // Ack is raised on the transition into HOLD, so ACK is never entered.
            ACK:     state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            sram_csb_o   <= 1'b1;
            sram_web_o   <= 1'b1;
            sram_wmask_o <= '0;
            sram_addr_o  <= '0;
            sram_din_o   <= '0;
            o_range_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ack_q        <= ack_nxt;
            dat_q        <= dat_nxt;
            sram_csb_o   <= csb_nxt;
            sram_web_o   <= web_nxt;
            sram_wmask_o <= wmask_nxt;
            sram_addr_o  <= addr_nxt;
            sram_din_o   <= din_nxt;
            o_range_err  <= rerr_nxt;
            o_busy       <= (state_nxt != IDLE);
        end
    end
endmodule
